// File: rtl/sa_tlb_module.sv
// Set-associative L2 TLB: per-set tree-PLRU, registered 1-cycle lookup, sfence.vma-style flushes.
// Full and VA flushes act at the accept edge; ASID-only flushes walk one set per cycle.
module sa_tlb_module #(
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 4,
  parameter int VPN_WIDTH  = 20,
  parameter int ASID_WIDTH = 9,
  parameter int PPN_WIDTH  = 22,
  parameter int FLAG_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_rdy,
  input  logic                  i_lkp_vld,
  input  logic [VPN_WIDTH-1:0]  i_lkp_vpn,
  input  logic [ASID_WIDTH-1:0] i_lkp_asid,
  output logic                  o_rsp_vld,
  output logic                  o_rsp_hit,
  output logic [PPN_WIDTH-1:0]  o_rsp_ppn,
  output logic [FLAG_WIDTH-1:0] o_rsp_flags,
  input  logic                  i_fill_vld,
  input  logic [VPN_WIDTH-1:0]  i_fill_vpn,
  input  logic [ASID_WIDTH-1:0] i_fill_asid,
  input  logic [PPN_WIDTH-1:0]  i_fill_ppn,
  input  logic [FLAG_WIDTH-1:0] i_fill_flags,
  input  logic                  i_flush_vld,
  input  logic                  i_flush_use_va,
  input  logic                  i_flush_use_asid,
  input  logic [VPN_WIDTH-1:0]  i_flush_vpn,
  input  logic [ASID_WIDTH-1:0] i_flush_asid,
  output logic                  o_flush_busy,
  output logic                  o_flush_done
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TAG_W  = VPN_WIDTH - IDX_W;
  localparam int PLRU_W = NUM_WAYS - 1;
  localparam int G_BIT  = 4;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        walk_cnt_q;
  logic [ASID_WIDTH-1:0]   flush_asid_q;

  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [PLRU_W-1:0]       plru_q  [NUM_SETS];
  logic [TAG_W-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
  logic [ASID_WIDTH-1:0]   asid_q  [NUM_SETS][NUM_WAYS];
  logic [PPN_WIDTH-1:0]    ppn_q   [NUM_SETS][NUM_WAYS];
  logic [FLAG_WIDTH-1:0]   flags_q [NUM_SETS][NUM_WAYS];

  logic                    rsp_vld_q, rsp_hit_q;
  logic [PPN_WIDTH-1:0]    rsp_ppn_q;
  logic [FLAG_WIDTH-1:0]   rsp_flags_q;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] res;
    int node;
    res  = bits;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      res[node] = ~way[WAY_W-1-lvl];
      node      = 2*node + 1 + int'(way[WAY_W-1-lvl]);
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] way;
    logic b;
    int node;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b                  = bits[node];
      way[WAY_W-1-lvl]   = b;
      node               = 2*node + 1 + int'(b);
    end
    return way;
  endfunction

  logic lkp_acc, fill_acc, flush_acc;
  assign o_rdy     = (state_q == IDLE);
  assign lkp_acc   = i_lkp_vld & o_rdy;
  assign fill_acc  = i_fill_vld & o_rdy & ~i_flush_vld;
  assign flush_acc = i_flush_vld & o_rdy;

  logic [IDX_W-1:0] lkp_idx, fill_idx, fva_idx;
  logic [TAG_W-1:0] lkp_tag, fill_tag, fva_tag;
  assign lkp_idx  = i_lkp_vpn[IDX_W-1:0];
  assign lkp_tag  = i_lkp_vpn[VPN_WIDTH-1:IDX_W];
  assign fill_idx = i_fill_vpn[IDX_W-1:0];
  assign fill_tag = i_fill_vpn[VPN_WIDTH-1:IDX_W];
  assign fva_idx  = i_flush_vpn[IDX_W-1:0];
  assign fva_tag  = i_flush_vpn[VPN_WIDTH-1:IDX_W];

  logic                lkp_hit, fill_hit, fill_has_inv;
  logic [WAY_W-1:0]    lkp_way, fill_hit_way, fill_inv_way, fill_way;
  logic [NUM_WAYS-1:0] fva_clr, walk_clr;

  // Downward scans leave the lowest-numbered matching way as the winner.
  always_comb begin
    lkp_hit      = 1'b0;
    lkp_way      = '0;
    fill_hit     = 1'b0;
    fill_hit_way = '0;
    fill_has_inv = 1'b0;
    fill_inv_way = '0;
    fva_clr      = '0;
    walk_clr     = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid_q[lkp_idx][w] && tag_q[lkp_idx][w] == lkp_tag &&
          (asid_q[lkp_idx][w] == i_lkp_asid || flags_q[lkp_idx][w][G_BIT])) begin
        lkp_hit = 1'b1;
        lkp_way = WAY_W'(w);
      end
      if (valid_q[fill_idx][w] && tag_q[fill_idx][w] == fill_tag &&
          (asid_q[fill_idx][w] == i_fill_asid || flags_q[fill_idx][w][G_BIT])) begin
        fill_hit     = 1'b1;
        fill_hit_way = WAY_W'(w);
      end
      if (!valid_q[fill_idx][w]) begin
        fill_has_inv = 1'b1;
        fill_inv_way = WAY_W'(w);
      end
      fva_clr[w]  = (tag_q[fva_idx][w] == fva_tag) &&
                    (!i_flush_use_asid ||
                     (asid_q[fva_idx][w] == i_flush_asid && !flags_q[fva_idx][w][G_BIT]));
      walk_clr[w] = (asid_q[walk_cnt_q][w] == flush_asid_q) && !flags_q[walk_cnt_q][w][G_BIT];
    end
    fill_way = fill_hit ? fill_hit_way :
               fill_has_inv ? fill_inv_way : plru_victim(plru_q[fill_idx]);
  end

  logic [PLRU_W-1:0] plru_lkp_d, plru_fill_base, plru_fill_d;
  always_comb begin
    plru_lkp_d     = plru_touch(plru_q[lkp_idx], lkp_way);
    plru_fill_base = (lkp_acc && lkp_hit && lkp_idx == fill_idx) ? plru_lkp_d : plru_q[fill_idx];
    plru_fill_d    = plru_touch(plru_fill_base, fill_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      if (lkp_acc && lkp_hit) plru_q[lkp_idx]  <= plru_lkp_d;
      if (fill_acc)           plru_q[fill_idx] <= plru_fill_d;
    end
  end

  // Fills, flushes and walk steps are mutually exclusive by the acceptance rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (flush_acc && !i_flush_use_va && !i_flush_use_asid) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      if (flush_acc && i_flush_use_va) valid_q[fva_idx] <= valid_q[fva_idx] & ~fva_clr;
      if (state_q == WALK)             valid_q[walk_cnt_q] <= valid_q[walk_cnt_q] & ~walk_clr;
      if (fill_acc)                    valid_q[fill_idx][fill_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_acc) begin
      tag_q[fill_idx][fill_way]   <= fill_tag;
      asid_q[fill_idx][fill_way]  <= i_fill_asid;
      ppn_q[fill_idx][fill_way]   <= i_fill_ppn;
      flags_q[fill_idx][fill_way] <= i_fill_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q   <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_ppn_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      rsp_vld_q   <= lkp_acc;
      rsp_hit_q   <= lkp_acc & lkp_hit;
      rsp_ppn_q   <= (lkp_acc && lkp_hit) ? ppn_q[lkp_idx][lkp_way]   : '0;
      rsp_flags_q <= (lkp_acc && lkp_hit) ? flags_q[lkp_idx][lkp_way] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      walk_cnt_q   <= '0;
      flush_asid_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (flush_acc) begin
          flush_asid_q <= i_flush_asid;
          state_q      <= (!i_flush_use_va && i_flush_use_asid) ? WALK : DONE;
        end
        WALK: begin
          if (walk_cnt_q == IDX_W'(NUM_SETS-1)) begin
            walk_cnt_q <= '0;
            state_q    <= DONE;
          end else begin
            walk_cnt_q <= walk_cnt_q + IDX_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rsp_vld    = rsp_vld_q;
  assign o_rsp_hit    = rsp_hit_q;
  assign o_rsp_ppn    = rsp_ppn_q;
  assign o_rsp_flags  = rsp_flags_q;
  assign o_flush_busy = (state_q != IDLE);
  assign o_flush_done = (state_q == DONE);

endmodule

// File: tb/tb_sa_tlb_module.sv
// Directed bench for sa_tlb_module: table of fills/lookups, then flush, PLRU and reset sequences.
module tb_sa_tlb_module;
  localparam int VW = 20;
  localparam int AW = 9;
  localparam int PW = 22;
  localparam int FW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          o_rdy;
  logic          i_lkp_vld = 1'b0;
  logic [VW-1:0] i_lkp_vpn = '0;
  logic [AW-1:0] i_lkp_asid = '0;
  logic          o_rsp_vld, o_rsp_hit;
  logic [PW-1:0] o_rsp_ppn;
  logic [FW-1:0] o_rsp_flags;
  logic          i_fill_vld = 1'b0;
  logic [VW-1:0] i_fill_vpn = '0;
  logic [AW-1:0] i_fill_asid = '0;
  logic [PW-1:0] i_fill_ppn = '0;
  logic [FW-1:0] i_fill_flags = '0;
  logic          i_flush_vld = 1'b0;
  logic          i_flush_use_va = 1'b0;
  logic          i_flush_use_asid = 1'b0;
  logic [VW-1:0] i_flush_vpn = '0;
  logic [AW-1:0] i_flush_asid = '0;
  logic          o_flush_busy, o_flush_done;

  always #5 clk = ~clk;

  sa_tlb_module #(
    .NUM_SETS(256), .NUM_WAYS(4), .VPN_WIDTH(VW), .ASID_WIDTH(AW), .PPN_WIDTH(PW), .FLAG_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .o_rdy(o_rdy),
    .i_lkp_vld(i_lkp_vld), .i_lkp_vpn(i_lkp_vpn), .i_lkp_asid(i_lkp_asid),
    .o_rsp_vld(o_rsp_vld), .o_rsp_hit(o_rsp_hit), .o_rsp_ppn(o_rsp_ppn), .o_rsp_flags(o_rsp_flags),
    .i_fill_vld(i_fill_vld), .i_fill_vpn(i_fill_vpn), .i_fill_asid(i_fill_asid),
    .i_fill_ppn(i_fill_ppn), .i_fill_flags(i_fill_flags),
    .i_flush_vld(i_flush_vld), .i_flush_use_va(i_flush_use_va), .i_flush_use_asid(i_flush_use_asid),
    .i_flush_vpn(i_flush_vpn), .i_flush_asid(i_flush_asid),
    .o_flush_busy(o_flush_busy), .o_flush_done(o_flush_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            is_fill;
    logic [VW-1:0] vpn;
    logic [AW-1:0] asid;
    logic [PW-1:0] ppn;
    logic [FW-1:0] flags;
    bit            hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit f, input logic [VW-1:0] v, input logic [AW-1:0] a,
                              input logic [PW-1:0] p, input logic [FW-1:0] fl, input bit h);
    vec_t r;
    r.is_fill = f; r.vpn = v; r.asid = a; r.ppn = p; r.flags = fl; r.hit = h;
    return r;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic do_fill(input logic [VW-1:0] v, input logic [AW-1:0] a,
                         input logic [PW-1:0] p, input logic [FW-1:0] fl);
    i_fill_vld = 1'b1; i_fill_vpn = v; i_fill_asid = a; i_fill_ppn = p; i_fill_flags = fl;
    @(negedge clk);
    i_fill_vld = 1'b0;
  endtask

  task automatic do_lkp(input logic [VW-1:0] v, input logic [AW-1:0] a, input bit h,
                        input logic [PW-1:0] p, input logic [FW-1:0] fl);
    logic [29:0] exp_rsp;
    i_lkp_vld = 1'b1; i_lkp_vpn = v; i_lkp_asid = a;
    @(negedge clk);
    i_lkp_vld = 1'b0;
    exp_rsp = h ? {1'b1, p, fl} : 30'd0;
    check($sformatf("rsp_vld %05h/%0d", v, a), 64'(o_rsp_vld), 64'd1);
    check($sformatf("rsp {hit,ppn,flags} %05h/%0d", v, a),
          64'({o_rsp_hit, o_rsp_ppn, o_rsp_flags}), 64'(exp_rsp));
  endtask

  int busy_cnt, done_cnt, rdy_seen;

  initial begin
    // Main table: basic hit/miss, G handling, duplicate-free refill, PLRU eviction in set 0x07.
    vecs.push_back(mk(0, 20'h12345, 1, 0, 0, 0));
    vecs.push_back(mk(1, 20'h00A05, 3, 22'h3ABCD, 7'h0F, 0));
    vecs.push_back(mk(0, 20'h00A05, 3, 22'h3ABCD, 7'h0F, 1));
    vecs.push_back(mk(0, 20'h00A05, 4, 0, 0, 0));
    vecs.push_back(mk(1, 20'h00A05, 3, 22'h3ABCD, 7'h1F, 0));
    vecs.push_back(mk(0, 20'h00A05, 4, 22'h3ABCD, 7'h1F, 1));
    vecs.push_back(mk(1, 20'h00B05, 3, 22'h00B05, 7'h0F, 0));
    vecs.push_back(mk(1, 20'h00C05, 3, 22'h00C05, 7'h0F, 0));
    vecs.push_back(mk(1, 20'h00D05, 3, 22'h00D05, 7'h0F, 0));
    vecs.push_back(mk(0, 20'h00A05, 3, 22'h3ABCD, 7'h1F, 1));
    vecs.push_back(mk(0, 20'h00B05, 3, 22'h00B05, 7'h0F, 1));
    vecs.push_back(mk(0, 20'h00C05, 3, 22'h00C05, 7'h0F, 1));
    vecs.push_back(mk(0, 20'h00D05, 3, 22'h00D05, 7'h0F, 1));
    for (int t = 1; t <= 5; t++)
      vecs.push_back(mk(1, 20'((t << 8) | 7), 1, 22'((t << 8) | 7), 7'h07, 0));
    vecs.push_back(mk(0, 20'h00507, 1, 22'h507, 7'h07, 1));
    vecs.push_back(mk(1, 20'h00607, 1, 22'h607, 7'h07, 0));
    vecs.push_back(mk(0, 20'h00107, 1, 0, 0, 0));
    vecs.push_back(mk(0, 20'h00307, 1, 0, 0, 0));
    vecs.push_back(mk(0, 20'h00207, 1, 22'h207, 7'h07, 1));
    vecs.push_back(mk(0, 20'h00407, 1, 22'h407, 7'h07, 1));
    vecs.push_back(mk(0, 20'h00507, 1, 22'h507, 7'h07, 1));
    vecs.push_back(mk(0, 20'h00607, 1, 22'h607, 7'h07, 1));
    vecs.push_back(mk(1, 20'h00E10, 5, 22'h00E10, 7'h0F, 0));
    vecs.push_back(mk(1, 20'h00F11, 3, 22'h00F11, 7'h0F, 0));

    repeat (3) @(negedge clk);
    check("reset o_rdy", 64'(o_rdy), 64'd1);
    check("reset rsp", 64'({o_rsp_vld, o_rsp_hit, o_rsp_ppn, o_rsp_flags}), 64'd0);
    check("reset busy/done", 64'({o_flush_busy, o_flush_done}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset o_rdy", 64'(o_rdy), 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_fill) do_fill(vecs[i].vpn, vecs[i].asid, vecs[i].ppn, vecs[i].flags);
      else do_lkp(vecs[i].vpn, vecs[i].asid, vecs[i].hit, vecs[i].ppn, vecs[i].flags);
    end
    check("idle rsp_vld", 64'(o_rsp_vld), 64'd0);

    // ASID-only flush walk for asid 3, with held request, blocked fill and blocked lookup.
    i_flush_vld = 1'b1; i_flush_use_va = 1'b0; i_flush_use_asid = 1'b1; i_flush_asid = 3;
    @(negedge clk);
    busy_cnt = 0; done_cnt = 0; rdy_seen = 0;
    for (int c = 0; c < 1000 && o_flush_busy; c++) begin
      busy_cnt++;
      if (o_flush_done) done_cnt++;
      if (o_rdy) rdy_seen++;
      if (c == 10) i_flush_vld = 1'b0;
      if (c == 3) begin
        i_fill_vld = 1'b1; i_fill_vpn = 20'h00C22; i_fill_asid = 7;
        i_fill_ppn = 22'h0C22; i_fill_flags = 7'h0F;
        i_lkp_vld = 1'b1; i_lkp_vpn = 20'h00207; i_lkp_asid = 1;
      end
      if (c == 4) begin
        i_fill_vld = 1'b0; i_lkp_vld = 1'b0;
        check("rsp_vld during walk", 64'(o_rsp_vld), 64'd0);
      end
      @(negedge clk);
    end
    i_flush_vld = 1'b0;
    check("walk busy cycles", 64'(busy_cnt), 64'd257);
    check("walk done pulses", 64'(done_cnt), 64'd1);
    check("walk o_rdy seen", 64'(rdy_seen), 64'd0);
    check("after walk done", 64'({o_flush_done, o_rdy}), 64'b01);
    do_lkp(20'h00A05, 3, 1, 22'h3ABCD, 7'h1F);
    do_lkp(20'h00B05, 3, 0, 0, 0);
    do_lkp(20'h00C05, 3, 0, 0, 0);
    do_lkp(20'h00D05, 3, 0, 0, 0);
    do_lkp(20'h00E10, 5, 1, 22'h00E10, 7'h0F);
    do_lkp(20'h00F11, 3, 0, 0, 0);
    do_lkp(20'h00207, 1, 1, 22'h207, 7'h07);
    do_lkp(20'h00C22, 7, 0, 0, 0);

    // VA+ASID flush: only the non-global asid 3 copy of 0x00A05 goes away.
    do_fill(20'h00A05, 3, 22'h22, 7'h0F);
    do_fill(20'h00A05, 6, 22'h66, 7'h0F);
    do_fill(20'h00A06, 3, 22'h33, 7'h0F);
    i_flush_vld = 1'b1; i_flush_use_va = 1'b1; i_flush_use_asid = 1'b1;
    i_flush_vpn = 20'h00A05; i_flush_asid = 3;
    @(negedge clk);
    i_flush_vld = 1'b0;
    check("va flush cycle1 {done,busy,rdy}", 64'({o_flush_done, o_flush_busy, o_rdy}), 64'b110);
    @(negedge clk);
    check("va flush cycle2 {done,busy,rdy}", 64'({o_flush_done, o_flush_busy, o_rdy}), 64'b001);
    do_lkp(20'h00A05, 3, 0, 0, 0);
    do_lkp(20'h00A05, 6, 1, 22'h66, 7'h0F);
    do_lkp(20'h00A06, 3, 1, 22'h33, 7'h0F);
    do_lkp(20'h00207, 1, 1, 22'h207, 7'h07);

    // Full flush with a same-cycle lookup that must see pre-flush contents.
    i_flush_vld = 1'b1; i_flush_use_va = 1'b0; i_flush_use_asid = 1'b0;
    do_lkp(20'h00207, 1, 1, 22'h207, 7'h07);
    i_flush_vld = 1'b0;
    check("full flush done", 64'(o_flush_done), 64'd1);
    @(negedge clk);
    do_lkp(20'h00207, 1, 0, 0, 0);
    do_lkp(20'h00A05, 6, 0, 0, 0);
    do_lkp(20'h00E10, 5, 0, 0, 0);

    // Reset in the middle of an ASID walk.
    do_fill(20'h00207, 1, 22'h207, 7'h07);
    do_fill(20'h00E10, 5, 22'h00E10, 7'h0F);
    i_flush_vld = 1'b1; i_flush_use_va = 1'b0; i_flush_use_asid = 1'b1; i_flush_asid = 9;
    @(negedge clk);
    i_flush_vld = 1'b0;
    repeat (100) @(negedge clk);
    check("mid-walk busy", 64'(o_flush_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset mid-walk {busy,done,rdy}", 64'({o_flush_busy, o_flush_done, o_rdy}), 64'b001);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (o_flush_done) done_cnt++;
    end
    check("no done after reset", 64'(done_cnt), 64'd0);
    do_lkp(20'h00207, 1, 0, 0, 0);
    do_lkp(20'h00E10, 5, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sa_tlb_module.md
Name: sa_tlb_module

Overview:
- Parametrised set-associative second-level TLB. It is the successor of the fixed 256x4 L2 TLB and sits between the L1 TLBs and the page-table walker in the MMU.
- Adds configurable sets, ways and widths, plus a registered 1-cycle lookup response.
- Adds tree-PLRU replacement per set, hit-refresh on fill, and sfence.vma-style flushes: full, by VA, by ASID, by VA+ASID.
- ASID-only flush runs as a set-walking state machine.

Parameters:
- NUM_SETS, 256, sets; power of 2, >=2; index = i_*_vpn[log2(NUM_SETS)-1:0]
- NUM_WAYS, 4, ways; power of 2, >=2
- VPN_WIDTH, 20, virtual page number width
- ASID_WIDTH, 9, ASID width
- PPN_WIDTH, 22, physical page number width
- FLAG_WIDTH, 7, stored PTE[7:1] = {D,A,G,U,X,W,R}; G = flags[4]

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- o_rdy  out  1  block accepts lookup/fill/flush; = (state==IDLE)
- i_lkp_vld  in  1  lookup request
- i_lkp_vpn  in  VPN_WIDTH  lookup VPN
- i_lkp_asid  in  ASID_WIDTH  lookup ASID
- o_rsp_vld  out  1  lookup response valid (1 cycle after accepted request)
- o_rsp_hit  out  1  lookup hit
- o_rsp_ppn  out  PPN_WIDTH  hit PPN (0 on miss)
- o_rsp_flags  out  FLAG_WIDTH  hit flags (0 on miss)
- i_fill_vld  in  1  write entry (from walker)
- i_fill_vpn  in  VPN_WIDTH  fill VPN
- i_fill_asid  in  ASID_WIDTH  fill ASID
- i_fill_ppn  in  PPN_WIDTH  fill PPN
- i_fill_flags  in  FLAG_WIDTH  fill flags
- i_flush_vld  in  1  flush request
- i_flush_use_va  in  1  restrict flush to i_flush_vpn
- i_flush_use_asid  in  1  restrict flush to i_flush_asid, non-global entries only
- i_flush_vpn  in  VPN_WIDTH  flush VPN
- i_flush_asid  in  ASID_WIDTH  flush ASID
- o_flush_busy  out  1  flush in progress (WALK or DONE)
- o_flush_done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset values: all valid bits 0, all PLRU bits 0, state IDLE, walk counter 0. o_rsp_vld/o_rsp_hit/o_flush_busy/o_flush_done = 0; o_rsp_ppn/o_rsp_flags = 0; o_rdy = 1. Tag/data arrays are not reset.
- Entry: {valid, tag = vpn[VPN_WIDTH-1:log2 NUM_SETS], asid, ppn, flags}.
- Hit: valid & tag equal & (asid equal | G).
- Lookup: accepted when i_lkp_vld & o_rdy.
  - Response registered next cycle: o_rsp_vld=1; hit data from the lowest-numbered hitting way.
  - Multiple hits are illegal but resolved that way.
  - o_rsp_vld=0 in any cycle without an accepted lookup; hit/ppn/flags are then 0.
- Fill: accepted when i_fill_vld & o_rdy & ~i_flush_vld. Way choice:
  - (a) a way already hitting for {fill vpn, fill asid} is overwritten (no duplicates);
  - (b) otherwise the lowest invalid way;
  - (c) otherwise the PLRU victim.
  - Written valid=1 at the clock edge.
- Same-cycle lookup + fill: lookup sees pre-fill contents (read-before-write).
- Tree-PLRU: NUM_WAYS-1 bits per set. Node bit 0 sends the victim search to the lower half, 1 to the upper half.
  - Touch sets every node on the path to point away from the touched way.
  - An accepted lookup hit touches the hit way; an accepted fill touches the written way.
  - Both in the same set in one cycle: the fill touch is applied after (overrides) the lookup touch.
  - Flushes do not change PLRU bits.
- Flush accepted when i_flush_vld & state==IDLE. While busy, i_flush_vld is ignored and the requester holds it. Invalidation rules:
  - use_va=0, use_asid=0: clear all valid bits at the accept edge.
  - use_va=1: in set idx(flush_vpn), clear ways with tag match; if use_asid=1, additionally require asid match & ~G. Takes effect at the accept edge.
  - use_va=0, use_asid=1: enter WALK. Counter steps 0..NUM_SETS-1, one set per cycle, clearing ways with asid match & ~G. Takes NUM_SETS cycles.
- FSM:
  - IDLE -> DONE on an accepted full or VA flush.
  - IDLE -> WALK on an accepted ASID-only flush.
  - WALK -> DONE when counter==NUM_SETS-1 (counter returns to 0).
  - DONE -> IDLE unconditionally.
  - o_flush_done=1 only in DONE. o_flush_busy = (state!=IDLE).
- Same-cycle flush + lookup in IDLE: the lookup is served from pre-flush contents. The next accepted lookup observes the flush.
- Reset asserted mid-walk: immediate return to IDLE, all entries invalid, no done pulse.

Test Plan:
- After reset: lookup vpn=0x12345, asid=1 -> next cycle o_rsp_vld=1, o_rsp_hit=0, ppn=0; o_rdy=1.
- Fill vpn=0x00A05, asid=3, ppn=0x3ABCD, flags=0x0F; lookup same vpn with asid=3 -> hit, ppn=0x3ABCD. Lookup with asid=4 -> miss. Refill with G set (flags=0x1F) -> asid=4 hits, still a single way used in set 0x05.
- Fill 5 distinct tags into set 0x07 (ways fill 0..3). Hit way 0, then fill a 6th tag -> it does not replace way 0; it replaces the PLRU victim, and the evicted tag misses.
- ASID-only flush asid=3 with entries {asid3 non-G, asid3 G, asid5} -> o_flush_busy for 256 cycles plus DONE, o_flush_done pulses once; only the asid3 non-G entry misses. o_rdy=0 throughout, and a fill during the walk is dropped.
- VA+ASID flush vpn=0x00A05, asid=3 -> done pulse in cycle 2; other sets untouched. Full flush -> every prior entry misses.
- Assert rst_n=0 at walk cycle 100 -> state IDLE, o_flush_busy=0, no o_flush_done, all lookups miss.
